// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Instruction fetch front end. It drives a program counter into a
// combinational instruction memory and presents each fetched word to a
// consumer through a valid/ready output register. Fetch stops after an
// instruction whose opcode field matches HALT_OP; the sequencer then waits for
// that instruction to be accepted and parks in HALT until the next start.
// A redirect (taken branch/jump) flushes the output register and restarts
// fetch at the redirect target.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-high reset
//   start          one-cycle pulse: begin fetching at start_addr (IDLE/HALT)
//   start_addr     first fetch address
//   adressIM       address to instruction memory (the pc register)
//   inst           memory data for adressIM, valid in the same cycle
//   out_valid      out_inst/out_pc hold a fetched instruction
//   out_ready      consumer accepts when out_valid and out_ready are high
//   out_inst       fetched instruction
//   out_pc         address of out_inst
//   redirect       flush and refetch from redirect_addr (FETCH/DRAIN)
//   redirect_addr  redirect target
//   halted         high while in HALT
//   fetch_cnt      number of accepted instructions, saturating at 255
// -----------------------------------------------------------------------------
module fetch_sequencer #(
   parameter int          ADDR_W  = 5,
   parameter int          DATA_W  = 32,
   parameter logic [5:0]  HALT_OP = 6'b111111
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   output logic [ADDR_W-1:0] adressIM,
   input  logic [DATA_W-1:0] inst,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_inst,
   output logic [ADDR_W-1:0] out_pc,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_addr,
   output logic              halted,
   output logic [7:0]        fetch_cnt
);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DRAIN,
      HALT
   } state_t;

   localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [7:0]        CNT_MAX = 8'hFF;

   state_t            state;
   logic [ADDR_W-1:0] pc;

   logic accept;    // consumer takes the current output entry this edge
   logic capture;   // output register is free (empty or being emptied)
   logic is_halt;   // word on the memory bus is a halt instruction
   logic cnt_inc;   // fetch_cnt may still count up

   assign accept   = out_valid & out_ready;
   assign capture  = ~out_valid | out_ready;
   assign is_halt  = (inst[31:26] == HALT_OP);
   assign cnt_inc  = (fetch_cnt != CNT_MAX);

   assign adressIM = pc;
   assign halted   = (state == HALT);

   // NOTE: every register below is assigned with <= so all updates within a
   // clock edge see the pre-edge values; blocking assignments here would make
   // the result depend on statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         pc        <= '0;
         out_valid <= 1'b0;
         out_inst  <= '0;
         out_pc    <= '0;
         fetch_cnt <= '0;
      end else begin
         case (state)
            // Waiting for a program to run; redirect is meaningless here.
            IDLE, HALT: begin
               out_valid <= 1'b0;
               if (start) begin
                  pc        <= start_addr;
                  fetch_cnt <= '0;
                  state     <= FETCH;
               end
            end

            FETCH: begin
               if (redirect) begin
                  // The displayed entry belongs to the wrong path: drop it
                  // without counting it, even if the consumer is taking it.
                  pc        <= redirect_addr;
                  out_valid <= 1'b0;
               end else begin
                  if (accept && cnt_inc) begin
                     fetch_cnt <= fetch_cnt + 8'd1;
                  end
                  // Capturing while the old entry is accepted refills the
                  // register in the same edge, giving one word per cycle.
                  if (capture) begin
                     out_inst  <= inst;
                     out_pc    <= pc;
                     out_valid <= 1'b1;
                     if (is_halt) begin
                        // pc stays on the halt word; nothing past it is fetched.
                        state <= DRAIN;
                     end else begin
                        pc <= pc + PC_ONE;
                     end
                  end
               end
            end

            // The halt instruction sits in the output register until taken.
            DRAIN: begin
               if (redirect) begin
                  pc        <= redirect_addr;
                  out_valid <= 1'b0;
                  state     <= FETCH;
               end else if (accept) begin
                  out_valid <= 1'b0;
                  if (cnt_inc) begin
                     fetch_cnt <= fetch_cnt + 8'd1;
                  end
                  state <= HALT;
               end
            end

            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Self-checking bench for fetch_sequencer. The stimulus side pushes the
// expected address stream of a program (start/redirect target onward, up to
// and including the first halt word) into a queue; a monitor on the falling
// clock edge pops one entry per accepted instruction and compares out_pc,
// out_inst and the running acceptance count. Directed sections cover the
// sequential run, pc wrap, stall, redirect flush, halt/restart, mid-cycle
// reset and count saturation; a randomized section follows.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

   localparam int AW = 5;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start;
   logic [AW-1:0] start_addr;
   logic [AW-1:0] adressIM;
   logic [DW-1:0] inst;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_inst;
   logic [AW-1:0] out_pc;
   logic          redirect;
   logic [AW-1:0] redirect_addr;
   logic          halted;
   logic [7:0]    fetch_cnt;

   // Combinational instruction memory.
   logic [31:0] mem [32];
   assign inst = mem[adressIM];

   fetch_sequencer #(
      .ADDR_W (AW),
      .DATA_W (DW),
      .HALT_OP(6'b111111)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .start_addr   (start_addr),
      .adressIM     (adressIM),
      .inst         (inst),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_inst     (out_inst),
      .out_pc       (out_pc),
      .redirect     (redirect),
      .redirect_addr(redirect_addr),
      .halted       (halted),
      .fetch_cnt    (fetch_cnt)
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------- checking
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------------------------------------------------- reference model
   logic [4:0] q [$];          // expected addresses of future acceptances
   int         model_cnt    = 0;
   bit         model_active = 1'b0;   // a program is running (FETCH/DRAIN)
   bit         model_halted = 1'b0;

   function automatic bit is_halt_word(input logic [31:0] w);
      return (w[31:26] == 6'h3F);
   endfunction

   // A program from address a runs a, a+1, ... (mod 32) through the first
   // halt word. Capped so a halt-free memory still yields a finite list.
   function automatic void push_trace(input logic [4:0] a);
      logic [4:0] p;
      p = a;
      q.delete();
      for (int n = 0; n < 400; n++) begin
         q.push_back(p);
         if (is_halt_word(mem[p])) break;
         p = 5'((int'(p) + 1) % 32);
      end
   endfunction

   // Monitor: compares the state reached so far, then applies the inputs that
   // the coming rising edge will sample.
   bit         mon_was_active;
   logic [4:0] mon_a;

   always @(negedge clk) begin
      if (!rst) begin
         mon_was_active = model_active;
         check("fetch_cnt", 32'(fetch_cnt), 32'(model_cnt));
         check("halted", 32'(halted), 32'(model_halted));
         if (!model_active) check("idle_out_valid", 32'(out_valid), 0);
         if (out_valid && out_ready && !redirect) begin
            if (q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_accept: got out_pc %0d expected no output", out_pc);
            end else begin
               mon_a = q.pop_front();
               check("acc_out_pc", 32'(out_pc), 32'(mon_a));
               check("acc_out_inst", out_inst, mem[mon_a]);
               if (model_cnt < 255) model_cnt++;
               if (is_halt_word(mem[mon_a])) begin
                  model_active = 1'b0;
                  model_halted = 1'b1;
               end
            end
         end
         if (start && !mon_was_active) begin
            model_cnt    = 0;
            model_active = 1'b1;
            model_halted = 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------- stimulus
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [4:0] a);
      start_addr = a;
      start      = 1'b1;
      if (!model_active) push_trace(a);
      step();
      start = 1'b0;
   endtask

   task automatic do_redirect(input logic [4:0] a);
      redirect_addr = a;
      redirect      = 1'b1;
      if (model_active) push_trace(a);
      step();
      redirect = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_out_valid"}, 32'(out_valid), 0);
      check({tag, "_out_pc"},    32'(out_pc),    0);
      check({tag, "_out_inst"},  out_inst,       0);
      check({tag, "_fetch_cnt"}, 32'(fetch_cnt), 0);
      check({tag, "_halted"},    32'(halted),    0);
      check({tag, "_adressIM"},  32'(adressIM),  0);
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic mid_reset();
      #1;
      rst = 1'b1;
      q.delete();
      model_cnt    = 0;
      model_active = 1'b0;
      model_halted = 1'b0;
      #1;
      check_all_zero("async_rst");
      rst = 1'b0;
   endtask

   task automatic randomize_mem();
      logic [5:0] op;
      for (int i = 0; i < 32; i++) begin
         op = 6'($urandom_range(0, 62));
         if ($urandom_range(0, 7) == 0) op = 6'h3F;
         mem[i] = {op, 26'($urandom)};
      end
   endtask

   initial begin
      start = 1'b0;  start_addr = '0;
      redirect = 1'b0;  redirect_addr = '0;
      out_ready = 1'b0;
      for (int i = 0; i < 32; i++) mem[i] = 32'(i);

      // Reset state.
      #1 rst = 1'b1;
      #1 check_all_zero("reset");
      @(posedge clk); #1;
      rst = 1'b0;
      step(); step();
      check("idle_no_fetch", 32'(out_valid), 0);

      // Sequential run from 3 with the consumer always ready.
      out_ready = 1'b1;
      do_start(5'd3);
      repeat (6) step();
      check("seq_out_pc", 32'(out_pc), 8);
      check("seq_fetch_cnt", 32'(fetch_cnt), 5);

      // Wrap 30, 31, 0, 1.
      do_redirect(5'd30);
      repeat (5) step();
      check("wrap_out_pc", 32'(out_pc), 2);

      // Stall three cycles at out_pc 7.
      out_ready = 1'b0;
      do_redirect(5'd7);
      step();
      for (int i = 0; i < 3; i++) begin
         check("stall_out_valid", 32'(out_valid), 1);
         check("stall_out_pc",    32'(out_pc),    7);
         check("stall_out_inst",  out_inst,        7);
         check("stall_adressIM",  32'(adressIM),  8);
         step();
      end
      out_ready = 1'b1;
      repeat (3) step();

      // Redirect to 17 while stalled at 9, consumer ready in the same cycle.
      out_ready = 1'b0;
      do_redirect(5'd9);
      step();
      check("pre_redir_out_pc", 32'(out_pc), 9);
      out_ready = 1'b1;
      do_redirect(5'd17);
      check("redir_out_valid", 32'(out_valid), 0);
      check("redir_adressIM",  32'(adressIM),  17);
      check("redir_fetch_cnt", 32'(fetch_cnt), 32'(model_cnt));
      step();
      check("redir_new_valid", 32'(out_valid), 1);
      check("redir_new_pc",    32'(out_pc),    17);
      repeat (2) step();

      // Halt instruction at 5: drain, halt, ignore redirect, restart at 0.
      out_ready = 1'b0;
      mem[5] = 32'hFC00_0000;
      do_redirect(5'd5);
      step();
      check("drain_out_pc",   32'(out_pc),   5);
      check("drain_adressIM", 32'(adressIM), 5);
      step();
      check("drain_hold_adr", 32'(adressIM), 5);
      check("drain_valid",    32'(out_valid), 1);
      check("drain_halted",   32'(halted),    0);
      out_ready = 1'b1;
      step();
      check("halt_halted", 32'(halted),    1);
      check("halt_valid",  32'(out_valid), 0);
      do_redirect(5'd9);
      check("halt_ign_redir", 32'(halted),   1);
      check("halt_ign_adr",   32'(adressIM), 5);
      do_start(5'd0);
      check("restart_halted", 32'(halted),    0);
      check("restart_cnt",    32'(fetch_cnt), 0);
      repeat (4) step();
      check("restart_out_pc", 32'(out_pc),    3);
      check("restart_cnt3",   32'(fetch_cnt), 3);

      // Reset pulse between edges mid-fetch; nothing happens until start.
      mid_reset();
      repeat (4) step();
      check("post_rst_valid", 32'(out_valid), 0);
      check("post_rst_adr",   32'(adressIM),  0);

      // Saturation of fetch_cnt on a halt-free memory.
      for (int i = 0; i < 32; i++) mem[i] = 32'(i);
      do_start(5'd0);
      repeat (260) step();
      check("cnt_saturate", 32'(fetch_cnt), 255);

      // Randomized programs, stalls, redirects and stray starts.
      mid_reset();
      randomize_mem();
      for (int it = 0; it < 1500; it++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         if (!model_active && $urandom_range(0, 3) == 0) begin
            if ($urandom_range(0, 1) == 0) randomize_mem();
            do_start(5'($urandom_range(0, 31)));
         end else if ($urandom_range(0, 11) == 0) begin
            do_redirect(5'($urandom_range(0, 31)));
         end else if ($urandom_range(0, 19) == 0) begin
            do_start(5'($urandom_range(0, 31)));
         end else begin
            step();
         end
      end
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, instruction-memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, instruction width.
REQ-003 SHALL have parameter HALT_OP, default 6'b111111, opcode in inst[31:26] that halts fetch.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse; begin fetching at start_addr.
REQ-007 SHALL have port start_addr  input  ADDR_W  first fetch address.
REQ-008 SHALL have port adressIM  output  ADDR_W  address to combinational instruction memory; always equals pc.
REQ-009 SHALL have port inst  input  DATA_W  memory data for adressIM, valid in the same cycle.
REQ-010 SHALL have port out_valid  output  1  out_inst/out_pc hold a fetched instruction.
REQ-011 SHALL have port out_ready  input  1  consumer accepts when out_valid and out_ready are both high.
REQ-012 SHALL have port out_inst  output  DATA_W  fetched instruction.
REQ-013 SHALL have port out_pc  output  ADDR_W  address of out_inst.
REQ-014 SHALL have port redirect  input  1  branch/jump taken; flush and refetch.
REQ-015 SHALL have port redirect_addr  input  ADDR_W  redirect target.
REQ-016 SHALL have port halted  output  1  high in HALT state.
REQ-017 SHALL have port fetch_cnt  output  8  count of accepted instructions.

Function
REQ-018 SHALL implement states IDLE, FETCH, DRAIN, HALT.
REQ-019 IDLE: out_valid=0; start -> pc=start_addr, fetch_cnt=0, go FETCH next edge.
REQ-020 FETCH capture condition = !out_valid or out_ready; on capture: out_inst<=inst, out_pc<=pc, out_valid<=1, pc<=pc+1.
REQ-021 pc increment SHALL wrap modulo 2^ADDR_W (31 -> 0 at default).
REQ-022 FETCH stall (out_valid and !out_ready): pc, out_inst, out_pc, out_valid SHALL hold; adressIM stays stable.
REQ-023 Capture while out_valid and out_ready SHALL replace the accepted entry in the same edge (one instruction per cycle throughput, no bubble).
REQ-024 Captured inst[31:26]==HALT_OP: SHALL go DRAIN; pc not incremented; no further captures.
REQ-025 DRAIN: when out_valid and out_ready -> out_valid<=0, go HALT.
REQ-026 HALT: halted=1, out_valid=0; start -> same action as REQ-019; other inputs ignored.
REQ-027 redirect in FETCH or DRAIN SHALL take priority over capture, stall, and drain: pc<=redirect_addr, out_valid<=0, state<=FETCH; no acceptance counted that cycle.
REQ-028 redirect in IDLE or HALT SHALL be ignored; start in FETCH or DRAIN SHALL be ignored.
REQ-029 fetch_cnt SHALL increment on each out_valid and out_ready cycle not coinciding with redirect, saturating at 255.
REQ-030 Outputs SHALL be registered except adressIM (=pc register) and halted (state decode).

Reset
REQ-031 rst high SHALL immediately force state=IDLE, pc=0, out_valid=0, out_inst=0, out_pc=0, fetch_cnt=0, halted=0, regardless of clk.
REQ-032 rst asserted mid-fetch or mid-drain SHALL discard the in-flight instruction; after release the block waits for start.

Verification
REQ-033 Reset then start with start_addr=3, out_ready=1, mem[a]=a -> out_pc 3,4,5,... consecutive cycles, out_inst=out_pc, fetch_cnt increments each cycle.
REQ-034 start_addr=30, out_ready=1 -> out_pc sequence 30,31,0,1 (wrap).
REQ-035 out_ready low 3 cycles with out_valid=1, out_pc=7 -> out_pc/out_inst/adressIM hold 7/mem[7]/8; after release next out_pc=8, no skip or duplicate.
REQ-036 redirect=1, redirect_addr=17 while stalled at out_pc=9 -> next cycle out_valid=0, adressIM=17; following cycle out_pc=17; fetch_cnt unchanged by the flushed entry.
REQ-037 mem[5]=32'hFC000000 -> after capture adressIM holds 5, DRAIN; on acceptance halted=1, out_valid=0; start with start_addr=0 resumes at 0 with fetch_cnt=0.
REQ-038 rst pulse between clock edges during FETCH -> outputs zero immediately; no fetch until start.
